// File: rtl/clock_tick_monitor_if.sv
// Bundle of the monitor's data-side signals: the three divided clock inputs,
// the sticky-error clear, and the tick/lock/error outputs.
//   master : drives clk_*_in and clr_err, observes the outputs (bench / host)
//   slave  : the monitor itself
`timescale 1ns/1ps
interface clock_tick_monitor_if;
  logic       clk_1_in;
  logic       clk_6_in;
  logic       clk_100_in;
  logic       clr_err;
  logic       tick_1;
  logic       tick_6;
  logic       tick_100;
  logic [2:0] locked;   // bit0=1 Hz, bit1=6 Hz, bit2=100 Hz
  logic [2:0] err;      // same bit order as locked

  modport master (
    output clk_1_in, clk_6_in, clk_100_in, clr_err,
    input  tick_1, tick_6, tick_100, locked, err
  );

  modport slave (
    input  clk_1_in, clk_6_in, clk_100_in, clr_err,
    output tick_1, tick_6, tick_100, locked, err
  );
endinterface

// File: rtl/clock_tick_monitor.sv
// Monitors three slow divided clocks (1 Hz, 6 Hz, 100 Hz) against the 40 MHz
// system clock. Each channel synchronizes its input, emits a one-cycle tick per
// rising edge, measures the tick-to-tick period and tracks lock with a small
// IDLE/ARMED/LOCKED FSM. Period faults and timeouts set a sticky error bit.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - clock_tick_monitor_if.slave (inputs clk_*_in, clr_err;
//          outputs tick_*, locked[2:0], err[2:0])
`timescale 1ns/1ps

// One monitored channel.
module ctm_lane #(
  parameter int unsigned EXP = 8,
  parameter int unsigned TOL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr_err,
  output logic tick,
  output logic locked,
  output logic err
);
  // Bounds held one bit wider than the counter so cnt+1 never wraps.
  localparam int unsigned LO   = (EXP > TOL) ? EXP - TOL : 0;
  localparam int unsigned HI   = EXP + TOL;
  localparam logic [26:0] P_LO = LO[26:0];
  localparam logic [26:0] P_HI = HI[26:0];
  // Counter value on the edge where it would step to EXP+TOL+1.
  localparam logic [25:0] T_OUT = HI[25:0];

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2} st_t;

  logic        s1, s2, prev;
  logic        rise;
  logic [25:0] cnt;
  logic [26:0] period;
  logic        good, tmo;
  logic        err_set, locked_nxt, err_nxt;
  st_t         st, st_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

  // cnt is the number of edges since the last tick edge, so on the edge that
  // detects the next rise the elapsed period is cnt+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (rise)        cnt <= '0;
    else if (cnt != '1)   cnt <= cnt + 26'd1;
  end

  assign period = {1'b0, cnt} + 27'd1;
  assign good   = (period >= P_LO) && (period <= P_HI);
  assign tmo    = !rise && (cnt == T_OUT);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // FSM: next state
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (rise) st_nxt = ARMED;
      ARMED: begin
        if (rise)     st_nxt = good ? LOCKED : ARMED;
        else if (tmo) st_nxt = IDLE;
      end
      LOCKED: begin
        if (rise)     st_nxt = good ? LOCKED : ARMED;
        else if (tmo) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // FSM: outputs. A fresh error wins over a simultaneous clear.
  always_comb begin
    err_set    = (st != IDLE) && ((rise && !good) || tmo);
    locked_nxt = (st_nxt == LOCKED);
    err_nxt    = err_set | (err & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick   <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      tick   <= rise;
      locked <= locked_nxt;
      err    <= err_nxt;
    end
  end
endmodule

module clock_tick_monitor #(
  parameter int unsigned EXP_1   = 40000000,
  parameter int unsigned EXP_6   = 6666666,
  parameter int unsigned EXP_100 = 400000,
  parameter int unsigned TOL     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_tick_monitor_if.slave  bus
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] din, tick, locked, err;

  assign din = {bus.clk_100_in, bus.clk_6_in, bus.clk_1_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int unsigned EXP = (g == 0) ? EXP_1 : (g == 1) ? EXP_6 : EXP_100;
    ctm_lane #(.EXP(EXP), .TOL(TOL)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .din     (din[g]),
      .clr_err (bus.clr_err),
      .tick    (tick[g]),
      .locked  (locked[g]),
      .err     (err[g])
    );
  end

  assign bus.tick_1   = tick[0];
  assign bus.tick_6   = tick[1];
  assign bus.tick_100 = tick[2];
  assign bus.locked   = locked;
  assign bus.err      = err;
endmodule

// File: tb/tb_clock_tick_monitor.sv
`timescale 1ns/1ps
module tb_clock_tick_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;
  string tname = "init";

  clock_tick_monitor_if bus ();

  clock_tick_monitor #(.EXP_1(20), .EXP_6(12), .EXP_100(8), .TOL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] tick_vec();
    return {bus.tick_100, bus.tick_6, bus.tick_1};
  endfunction

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s got=%b exp=%b", tname, tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] m, input logic v);
    if (m[0]) bus.clk_1_in   = v;
    if (m[1]) bus.clk_6_in   = v;
    if (m[2]) bus.clk_100_in = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clk_1_in = 1'b0; bus.clk_6_in = 1'b0; bus.clk_100_in = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One input period of length p on the channels in m (high 4 cycles).
  // Tick expected exactly 3 negedges after the rise, nowhere else.
  task automatic per(input logic [2:0] m, input int p, input int clr_at);
    set_in(m, 1'b1);
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      chk($sformatf("tick%0d", i), tick_vec(), (i == 3) ? m : 3'b000);
      if (i == 4) set_in(m, 1'b0);
      bus.clr_err = (i == clr_at);
    end
  endtask

  task automatic step(input logic [2:0] m, input int p, input bit l, input bit e);
    per(m, p, -1);
    chk("locked", bus.locked, l ? m : 3'b000);
    chk("err",    bus.err,    e ? m : 3'b000);
  endtask

  initial begin
    int e;
    logic [2:0] m;
    bus.clk_1_in = 1'b0; bus.clk_6_in = 1'b0; bus.clk_100_in = 1'b0;
    bus.clr_err = 1'b0;

    // reset state
    tname = "reset";
    repeat (2) @(negedge clk);
    chk("tick", tick_vec(), 3'b000);
    chk("locked", bus.locked, 3'b000);
    chk("err", bus.err, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    // 100 Hz channel locks after the second tick
    tname = "lock100";
    step(3'b100, 8, 0, 0);
    step(3'b100, 8, 1, 0);
    step(3'b100, 8, 1, 0);
    step(3'b100, 8, 1, 0);

    // short 6 Hz period drops lock, next good period relocks, err sticks
    tname = "short6";
    do_reset();
    step(3'b010, 12, 0, 0);
    step(3'b010, 12, 1, 0);
    step(3'b010, 9,  1, 0);
    step(3'b010, 12, 0, 1);
    step(3'b010, 12, 1, 1);

    // 1 Hz timeout: tick at t0+3, drop to IDLE 22 cycles later
    tname = "tmo1";
    do_reset();
    step(3'b001, 20, 0, 0);
    step(3'b001, 20, 1, 0);
    repeat (4) @(negedge clk);
    chk("locked_pre", bus.locked, 3'b001);
    chk("err_pre", bus.err, 3'b000);
    @(negedge clk);
    chk("locked_post", bus.locked, 3'b000);
    chk("err_post", bus.err, 3'b001);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("err_clr", bus.err, 3'b000);
    step(3'b001, 20, 0, 0);
    step(3'b001, 20, 1, 0);

    // reset mid-period discards the partial measurement
    tname = "midrst";
    do_reset();
    step(3'b100, 8, 0, 0);
    step(3'b100, 8, 1, 0);
    set_in(3'b100, 1'b1);
    repeat (3) @(negedge clk);
    chk("tick_pre", tick_vec(), 3'b100);
    chk("locked_pre", bus.locked, 3'b100);
    rst = 1'b1;
    #1;
    chk("tick_rst", tick_vec(), 3'b000);
    chk("locked_rst", bus.locked, 3'b000);
    chk("err_rst", bus.err, 3'b000);
    @(negedge clk);
    set_in(3'b100, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    step(3'b100, 8, 0, 0);
    step(3'b100, 8, 1, 0);

    // input already high at reset release
    tname = "highrel";
    rst = 1'b1;
    bus.clk_6_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("tick_n2", tick_vec(), 3'b000);
    @(negedge clk);
    chk("tick_n3", tick_vec(), 3'b010);
    @(negedge clk);
    chk("tick_n4", tick_vec(), 3'b000);
    bus.clk_6_in = 1'b0;

    // tolerance boundaries on every channel
    for (int c = 0; c < 3; c++) begin
      e = (c == 0) ? 20 : (c == 1) ? 12 : 8;
      m = 3'b001 << c;
      tname = $sformatf("bnd_lo%0d", c);
      do_reset();
      step(m, e,     0, 0);
      step(m, e,     1, 0);
      step(m, e + 1, 1, 0);
      step(m, e - 1, 1, 0);
      step(m, e - 2, 1, 0);
      step(m, e,     0, 1);
      tname = $sformatf("bnd_hi%0d", c);
      do_reset();
      step(m, e,     0, 0);
      step(m, e,     1, 0);
      step(m, e + 2, 1, 0);
      step(m, e,     0, 1);
      step(m, e,     1, 1);
    end

    // simultaneous ticks on all channels, period 8
    tname = "simul";
    do_reset();
    per(3'b111, 8, -1);
    chk("locked1", bus.locked, 3'b000);
    chk("err1", bus.err, 3'b000);
    per(3'b111, 8, -1);
    chk("locked2", bus.locked, 3'b100);
    chk("err2", bus.err, 3'b011);

    // clr_err coinciding with a bad-period tick: set wins
    tname = "clrset";
    do_reset();
    step(3'b100, 8, 0, 0);
    step(3'b100, 6, 1, 0);
    per(3'b100, 8, 2);
    chk("locked", bus.locked, 3'b000);
    chk("err", bus.err, 3'b100);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_tick_monitor.md
CLOCK_TICK_MONITOR -- requirements
Module: clock_tick_monitor

Interface
REQ-001 Parameter EXP_1, default 40000000: expected 1 Hz input period, in clk cycles.
REQ-002 Parameter EXP_6, default 6666666: expected 6 Hz input period, in clk cycles.
REQ-003 Parameter EXP_100, default 400000: expected 100 Hz input period, in clk cycles.
REQ-004 Parameter TOL, default 2: allowed period deviation (+/-), in clk cycles.
REQ-005 clk  input  1  system clock (40 MHz); the only clock; all state on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clk_1_in, clk_6_in, clk_100_in  input  1 each  divided clock levels; treated as asynchronous data.
REQ-008 clr_err  input  1  synchronous; clears all sticky error flags.
REQ-009 tick_1, tick_6, tick_100  output  1 each  one-cycle pulse per input rising edge.
REQ-010 locked  output  3  per-channel lock status; bit0=1 Hz, bit1=6 Hz, bit2=100 Hz.
REQ-011 err  output  3  per-channel sticky period error; same bit order as locked.

Function
REQ-012 Each input SHALL pass through a two-flop synchronizer, followed by a third "previous" flop used for edge detection.
REQ-013 A channel's rising edge SHALL be detected when sync2=1 and prev=0.
REQ-014 The tick output SHALL be registered and high for exactly one cycle per detected edge.
REQ-015 Tick latency SHALL be 3 clk edges: an input high before edge N gives a tick visible after edge N+2. Falling edges SHALL produce no tick.
REQ-016 Each channel SHALL have a saturating period counter, 26 bits wide. The counter:
  - clears to 0 on a tick;
  - otherwise increments by 1 per cycle;
  - holds at all-ones.
REQ-017 Measured period P SHALL equal the clk-cycle distance between consecutive tick rising edges.
REQ-018 A period SHALL be "good" when EXP-TOL <= P <= EXP+TOL; otherwise it is "bad". The comparison SHALL use unsigned arithmetic with no wrap.
REQ-019 Each channel SHALL run an FSM with states IDLE, ARMED and LOCKED. Transitions:
  - IDLE -> ARMED on the first tick.
  - ARMED -> LOCKED on a tick ending a good period.
  - ARMED stays ARMED on a tick ending a bad period, and sets err.
  - LOCKED stays LOCKED on a tick ending a good period.
  - LOCKED -> ARMED on a tick ending a bad period, and sets err.
REQ-020 Timeout rule: in ARMED or LOCKED, when the counter reaches EXP+TOL+1 with no tick, the FSM SHALL go to IDLE and set err. A later tick SHALL then be treated as a first edge, with no period judged.
REQ-021 locked[i] SHALL be 1 exactly when channel i is in LOCKED, registered, and updated on the same edge as the state.
REQ-022 err[i] SHALL be sticky until clr_err is sampled high.
REQ-023 If clr_err and a new error event occur in the same cycle, err SHALL end that cycle at 1 (set wins).
REQ-024 The three channels SHALL be fully independent; simultaneous ticks on several channels SHALL each be handled in the same cycle.
REQ-025 A short period (tick before EXP-TOL) SHALL be judged bad at that tick, and counting SHALL restart from that tick.

Reset
REQ-026 While rst=1, all synchronizer, prev, counter, FSM and output flops SHALL be forced asynchronously to their reset values:
  - ticks 0;
  - locked=3'b000;
  - err=3'b000;
  - FSMs in IDLE;
  - counters 0.
REQ-027 A reset asserted mid-measurement SHALL discard the partial period. After rst falls, the first detected edge SHALL only arm the channel.
REQ-028 An input already high when rst falls SHALL produce a tick 3 edges later (prev resets to 0).

Verification (bench overrides EXP_1=20, EXP_6=12, EXP_100=8, TOL=1)
REQ-029 Drive clk_100_in with period 8 for 4 cycles -> tick_100 pulses 8 apart, each 1 cycle wide, 3 edges after each rise; locked[2]=1 after the 2nd tick; err[2]=0.
REQ-030 In the locked state, shorten one clk_6_in period to 9 -> at that tick err[1]=1 and locked[1]=0; with the next good period (12) locked[1]=1 again, and err[1] stays 1.
REQ-031 Stop clk_1_in while in LOCKED -> 22 cycles after the last tick, the channel goes to IDLE with locked[0]=0 and err[0]=1. Then pulse clr_err -> err[0]=0.
REQ-032 Assert rst for 2 cycles midway through a clk_100_in period -> all outputs read 0 immediately. The next rise gives a tick but no lock; lock follows only after one more good period.
REQ-033 Drive periods EXP+1 and EXP-1 -> judged good; EXP+2 and EXP-2 -> judged bad (boundary check on all three channels).
REQ-034 Pulse clr_err in the same cycle as a bad-period tick -> err stays 1.
